// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor with IDLE/RUN/DONE control.
// One bit per cycle, LSB first; registered result and borrow.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             bin;

  logic load;
  logic step;
  logic last;

  logic x;
  logic y;
  logic d1;
  logic b1;
  logic d;
  logic b2;
  logic bout;

  // Two chained half subtractors: (x - y), then (d1 - bin).
  assign x    = sa[0];
  assign y    = sb[0];
  assign d1   = x ^ y;
  assign b1   = ~x & y;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;

  assign last = (cnt == CW'(WIDTH - 1));

  // Next-state and datapath control.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          step = 1'b1;
          if (last) state_nx = DONE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register with registered busy/done flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      done  <= (state_nx == DONE);
    end
  end

  // Operand/result shifters, borrow, counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      cnt      <= '0;
      bin      <= 1'b0;
      diff     <= '0;
      borr_out <= 1'b0;
    end else if (load) begin
      sa  <= a;
      sb  <= b;
      sr  <= '0;
      cnt <= '0;
      bin <= 1'b0;
    end else if (step) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= {d, sr[WIDTH-1:1]};
      bin <= bout;
      cnt <= cnt + CW'(1);
      if (last) begin
        diff     <= {d, sr[WIDTH-1:1]};
        borr_out <= bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl at WIDTH=4.
// Vector table, corner sequences and an exhaustive sweep.
module tb_serial_subtractor_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borr_out;

  int checks;
  int errors;
  int cyc;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
  } exp_t;

  vec_t vt[6];
  exp_t sq[$];

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .diff(diff),
    .borr_out(borr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      if (sq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sq.pop_front();
        chk("diff", int'(diff), int'(e.d));
        chk("borr_out", int'(borr_out), int'(e.bo));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input logic bo);
    exp_t e;
    e.d  = d;
    e.bo = bo;
    sq.push_back(e);
  endtask

  // Accept one operation, check latency, busy span and return to IDLE.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic [W-1:0] ed, input logic eb,
                       input bit tmp_change);
    int k;
    int nb;
    a     = ta;
    b     = tb;
    start = 1'b1;
    push(ed, eb);
    tick();
    start = 1'b0;
    if (tmp_change) begin
      a = ~ta;
      b = ~tb;
    end
    k  = 0;
    nb = busy ? 1 : 0;
    while (!done && k < 20) begin
      tick();
      k++;
      if (busy) nb++;
    end
    chk("done_latency", k, W);
    chk("busy_cycles", nb, W + 1);
    tick();
    chk("idle_after_done", int'(busy), 0);
  endtask

  initial begin
    int t1;
    int t2;
    int t3;
    int n;
    int seen;
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    a      = '0;
    b      = '0;

    vt[0] = '{a: 4'd9,  b: 4'd3,  d: 4'd6,  bo: 1'b0};
    vt[1] = '{a: 4'd3,  b: 4'd9,  d: 4'hA,  bo: 1'b1};
    vt[2] = '{a: 4'd0,  b: 4'd1,  d: 4'hF,  bo: 1'b1};
    vt[3] = '{a: 4'd5,  b: 4'd5,  d: 4'd0,  bo: 1'b0};
    vt[4] = '{a: 4'd15, b: 4'd0,  d: 4'hF,  bo: 1'b0};
    vt[5] = '{a: 4'd0,  b: 4'd15, d: 4'd1,  bo: 1'b1};

    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_borr", int'(borr_out), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_start", int'(busy), 0);

    for (int i = 0; i < 6; i++)
      do_op(vt[i].a, vt[i].b, vt[i].d, vt[i].bo, 1'b0);

    // Operand changes after acceptance must not matter.
    do_op(4'd12, 4'd5, 4'd7, 1'b0, 1'b1);

    // start and abort together in IDLE: start wins.
    abort = 1'b1;
    a     = 4'd8;
    b     = 4'd2;
    start = 1'b1;
    push(4'd6, 1'b0);
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_beats_abort", int'(busy), 1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("sa_latency", n, W);
    // abort while in DONE is ignored; done stays one cycle.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("done_one_cycle", int'(done), 0);

    // start held high: results every W+2 cycles, extra starts ignored.
    a     = 4'd7;
    b     = 4'd2;
    start = 1'b1;
    for (int i = 0; i < 3; i++) push(4'd5, 1'b0);
    t1 = -1;
    t2 = -1;
    t3 = -1;
    n  = 0;
    while (t3 < 0 && n < 40) begin
      tick();
      n++;
      if (done) begin
        if (t1 < 0) t1 = cyc;
        else if (t2 < 0) t2 = cyc;
        else t3 = cyc;
      end
      if (t3 >= 0) start = 1'b0;
    end
    start = 1'b0;
    chk("held_gap1", t2 - t1, W + 2);
    chk("held_gap2", t3 - t2, W + 2);
    tick();

    // Complete 9-3, then abort 1-8 on its 2nd RUN edge.
    do_op(4'd9, 4'd3, 4'd6, 1'b0, 1'b0);
    a     = 4'd1;
    b     = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", int'(busy), 0);
    chk("abort_diff", int'(diff), 6);
    chk("abort_borr", int'(borr_out), 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen = 1;
      tick();
    end
    chk("abort_no_done", seen, 0);

    // Reset on the 3rd RUN edge.
    a     = 4'd2;
    b     = 4'd11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrun_rst_busy", int'(busy), 0);
    chk("midrun_rst_done", int'(done), 0);
    chk("midrun_rst_diff", int'(diff), 0);
    chk("midrun_rst_borr", int'(borr_out), 0);
    do_op(4'd4, 4'd4, 4'd0, 1'b0, 1'b0);

    // Exhaustive sweep against a reference model.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] ed;
        ea = W'(i);
        eb = W'(j);
        ed = ea - eb;
        do_op(ea, eb, ed, (i < j), 1'b0);
      end
    end

    tick();
    chk("queue_empty", sq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
